avalon_key_poller: RTL and testbench



---
 rtl/avalon_key_poller.sv | 136 +++++++++++++
 tb/tb_avalon_key_poller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_key_poller.sv
// Avalon-MM read master: polls the pushbutton PIO data register and debounces the key bits.
// Latency: one read every POLL_DIV+READ_LATENCY+2 cycles; key events are registered in the UPDATE cycle.
// Backpressure: avm_read and address are held while avm_waitrequest=1, with no timeout.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   enable            polling enable; low freezes the poll timer (an in-flight read still completes)
//   avm_*             Avalon-MM read master (address, read, waitrequest, readdata)
//   key_state         debounced key state, 1 = pressed
//   key_press/release one-cycle pulses on debounced 0->1 / 1->0 transitions
//   sample_valid      one-cycle pulse for every processed read sample
module avalon_key_poller #(
  parameter int KEY_W            = 4,
  parameter int POLL_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int READ_LATENCY     = 1,
  parameter int PIO_ADDR         = 0,
  parameter bit ACTIVE_LOW       = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic             sample_valid
);

  localparam int             TW           = $clog2(POLL_DIV);
  localparam logic [TW-1:0]  TIMER_RELOAD = TW'(POLL_DIV - 1);
  localparam int             CW           = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CW-1:0]  CNT_MAX      = CW'(DEBOUNCE_SAMPLES);
  localparam logic [1:0]     LAT_LOAD     = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, UPDATE} state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [1:0]       lat_cnt;
  logic [KEY_W-1:0] captured;
  logic [KEY_W-1:0] last_raw;
  logic [CW-1:0]    stable_cnt [KEY_W];

  logic [KEY_W-1:0] raw;
  logic [CW-1:0]    cnt_nxt [KEY_W];
  logic [KEY_W-1:0] change;
  logic             readdata_unused;

  assign avm_address = 2'(PIO_ADDR);

  // Bits at and above KEY_W carry nothing for us.
  assign readdata_unused = ^(avm_readdata >> KEY_W);

  // Per-bit debounce: a bit's run length restarts at 1 whenever the raw sample
  // differs from the previous sample; the debounced state follows only once the
  // run reaches DEBOUNCE_SAMPLES.
  always_comb begin
    raw    = ACTIVE_LOW ? ~captured : captured;
    change = '0;
    for (int i = 0; i < KEY_W; i++) begin
      cnt_nxt[i] = CW'(1);
      if (raw[i] == last_raw[i]) begin
        cnt_nxt[i] = (stable_cnt[i] == CNT_MAX) ? CNT_MAX : stable_cnt[i] + CW'(1);
      end
      change[i] = (cnt_nxt[i] == CNT_MAX) && (raw[i] != key_state[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      timer        <= TIMER_RELOAD;
      lat_cnt      <= '0;
      captured     <= '0;
      last_raw     <= '0;
      avm_read     <= 1'b0;
      key_state    <= '0;
      key_press    <= '0;
      key_release  <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < KEY_W; i++) begin
        stable_cnt[i] <= '0;
      end
    end else begin
      key_press    <= '0;
      key_release  <= '0;
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            if (timer == '0) begin
              state    <= REQ;
              avm_read <= 1'b1;
            end else begin
              timer <= timer - TW'(1);
            end
          end
        end
        REQ: begin
          // Command is accepted on the edge where waitrequest is low.
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            lat_cnt  <= LAT_LOAD;
            state    <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (lat_cnt == '0) begin
            captured <= avm_readdata[KEY_W-1:0];
            state    <= UPDATE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        UPDATE: begin
          for (int i = 0; i < KEY_W; i++) begin
            stable_cnt[i] <= cnt_nxt[i];
          end
          key_state    <= key_state ^ change;
          key_press    <= change & raw;
          key_release  <= change & ~raw;
          last_raw     <= raw;
          sample_valid <= 1'b1;
          timer        <= TIMER_RELOAD;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_key_poller.sv
module tb_avalon_key_poller;

  localparam int POLL_DIV = 4;
  localparam int PIO_ADDR = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata = 32'h0000_000F;
  logic [3:0]  key_state;
  logic [3:0]  key_press;
  logic [3:0]  key_release;
  logic        sample_valid;

  avalon_key_poller #(
    .KEY_W(4), .POLL_DIV(POLL_DIV), .DEBOUNCE_SAMPLES(3),
    .READ_LATENCY(1), .PIO_ADDR(PIO_ADDR), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ks;
    logic [3:0] pr;
    logic [3:0] rl;
    int         interval;   // 0 = interval not checked
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_sv = 0;

  // Directed sample table: read data and hand-computed response after each sample.
  logic [31:0] tbl_data [20] = '{32'hF, 32'hF, 32'hE, 32'hE, 32'hE, 32'hE, 32'hF, 32'hF, 32'hF,
                                 32'hE, 32'hF, 32'hE, 32'hE, 32'hE,
                                 32'h0, 32'h0, 32'h0,
                                 32'hFFFF_FFF5, 32'hFFFF_FFF5, 32'hFFFF_FFF5};
  logic [3:0]  tbl_ks [20]   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
                                 4'h1, 4'h1, 4'hF,
                                 4'hF, 4'hF, 4'hA};
  logic [3:0]  tbl_pr [20]   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
                                 4'h0, 4'h0, 4'hE,
                                 4'h0, 4'h0, 4'h0};
  logic [3:0]  tbl_rl [20]   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                 4'h0, 4'h0, 4'h0,
                                 4'h0, 4'h0, 4'h5};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] ks, input logic [3:0] pr, input logic [3:0] rl,
                          input int iv);
    exp_t e;
    e.ks = ks; e.pr = pr; e.rl = rl; e.interval = iv;
    exp_q.push_back(e);
  endtask

  // Counts rising edges until avm_read is seen high at a falling edge.
  task automatic count_to_read(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!avm_read && n < 500);
    if (!avm_read) begin
      total++;
      bad++;
      $display("FAIL read_timeout: got no read after %0d cycles expected one", n);
    end
  endtask

  task automatic wait_sample(input string nm);
    int n = 0;
    @(negedge clk);
    while (!sample_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!sample_valid) begin
      bad++;
      $display("FAIL %s_timeout: got no sample_valid expected one", nm);
    end
  endtask

  always @(posedge clk) cyc++;

  // Slave model: read data appears the cycle after the command is accepted.
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) begin
      if (rd_q.size() != 0) avm_readdata <= rd_q.pop_front();
      else                  avm_readdata <= 32'h0000_000F;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_sample: got sample_valid with key_state 0x%0h expected none", key_state);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("key_state", 32'(key_state), 32'(e.ks));
          check("key_press", 32'(key_press), 32'(e.pr));
          check("key_release", 32'(key_release), 32'(e.rl));
          if (e.interval != 0) check("sample_interval", 32'(cyc - last_sv), 32'(e.interval));
        end
        last_sv = cyc;
      end else begin
        check("idle_pulses", 32'({key_press, key_release}), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0;
    enable = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_avm_read", 32'(avm_read), 32'h0);
    check("reset_key_state", 32'(key_state), 32'h0);
    check("reset_key_press", 32'(key_press), 32'h0);
    check("reset_key_release", 32'(key_release), 32'h0);
    check("reset_sample_valid", 32'(sample_valid), 32'h0);
    check("address", 32'(avm_address), 32'(PIO_ADDR));

    // Clean press/release, bounce, multi-bit and upper-bit masking.
    for (int i = 0; i < 20; i++) begin
      rd_q.push_back(tbl_data[i]);
      push_exp(tbl_ks[i], tbl_pr[i], tbl_rl[i], (i == 0) ? 0 : 7);
    end
    reset_n = 1'b1;
    count_to_read(n);
    check("first_read_edges", 32'(n), 32'(POLL_DIV));
    for (int i = 0; i < 20; i++) wait_sample("table");

    // Five-cycle waitrequest stall.
    rd_q.push_back(32'hFFFF_FFF5);
    push_exp(4'hA, 4'h0, 4'h0, 12);
    avm_waitrequest = 1'b1;
    count_to_read(n);
    check("stall_read_edges", 32'(n), 32'(POLL_DIV));
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      check("stall_read_hold", 32'(avm_read), 32'h1);
      check("stall_addr_hold", 32'(avm_address), 32'(PIO_ADDR));
      if (k == 6) avm_waitrequest = 1'b0;
    end
    @(negedge clk);
    check("read_drop_after_accept", 32'(avm_read), 32'h0);
    wait_sample("stall");

    // Enable low in IDLE with timer=2.
    rd_q.push_back(32'hFFFF_FFF5);
    push_exp(4'hA, 4'h0, 4'h0, 17);
    @(negedge clk);
    enable = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("no_read_while_disabled", 32'(avm_read), 32'h0);
    end
    enable = 1'b1;
    count_to_read(n);
    check("read_after_reenable", 32'(n), 32'd3);
    wait_sample("enable_idle");

    // Enable low during WAIT_DATA: sample still processed.
    rd_q.push_back(32'hFFFF_FFF5);
    push_exp(4'hA, 4'h0, 4'h0, 7);
    rd_q.push_back(32'hFFFF_FFF5);
    push_exp(4'hA, 4'h0, 4'h0, 7);
    count_to_read(n);
    check("normal_read_edges", 32'(n), 32'(POLL_DIV));
    @(negedge clk);
    enable = 1'b0;
    wait_sample("enable_wait_data");
    enable = 1'b1;
    wait_sample("resume");

    // Reset pulse while in WAIT_DATA with all keys pressed on the bus.
    rd_q.push_back(32'h0);
    count_to_read(n);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("reset_async_read", 32'(avm_read), 32'h0);
    check("reset_async_key_state", 32'(key_state), 32'h0);
    push_exp(4'h0, 4'h0, 4'h0, 0);
    push_exp(4'h0, 4'h0, 4'h0, 7);
    @(negedge clk);
    reset_n = 1'b1;
    count_to_read(n);
    check("restart_read_edges", 32'(n), 32'(POLL_DIV));
    wait_sample("post_reset_1");
    wait_sample("post_reset_2");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
